// File: rtl/condition_checker_if.sv
// Instruction/result handshake bundle between the condition decoder, the
// condition checker and the execute stage.
interface condition_checker_if #(
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_cond;
  logic             in_sets_flags;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_execute;
  logic             out_undefined;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_cond, in_sets_flags, in_tag, out_ready,
    input  in_ready, out_valid, out_execute, out_undefined, out_tag
  );

  modport slave (
    input  in_valid, in_cond, in_sets_flags, in_tag, out_ready,
    output in_ready, out_valid, out_execute, out_undefined, out_tag
  );
endinterface

// File: rtl/condition_checker.sv
// Evaluates ARM condition codes against tracked NZCV flags and stalls on
// in-flight flag writes. Optional macro COND_FLAG_BYPASS_EN adds write-back bypass.
module condition_checker #(
  parameter int TAG_W  = 8,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  condition_checker_if.slave bus,
  input  logic              flag_wr_valid,
  input  logic [3:0]        flag_wr_nzcv,
  output logic [3:0]        flags_nzcv,
  output logic [PEND_W-1:0] pend_count,
  output logic              err_underflow
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  // Flags ordered {N,Z,C,V}; 0xF is the undefined encoding and never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  logic [3:0]        flags_reg;
  logic [PEND_W-1:0] pend_count_reg;
  logic              err_underflow_reg;
  logic              out_valid_reg;
  logic              out_execute_reg;
  logic              out_undefined_reg;
  logic [TAG_W-1:0]  out_tag_reg;

  logic [3:0]        eval_flags;
  logic [15:0]       pass_table;
  logic              pass;
  logic              undefined;
  logic              hazard;
  logic              hazard_eff;
  logic              accept;
  logic              pend_inc;
  logic              pend_dec;
  logic [PEND_W-1:0] pend_count_next;

  assign hazard = (pend_count_reg != '0) && (bus.in_cond != 4'hE) && (bus.in_cond != 4'hF);

`ifdef COND_FLAG_BYPASS_EN
  // The last outstanding write lands this cycle: evaluate against it directly.
  logic bypass_hit;
  assign bypass_hit = flag_wr_valid && (pend_count_reg == PEND_ONE);
  assign hazard_eff = hazard && !bypass_hit;
  assign eval_flags = bypass_hit ? flag_wr_nzcv : flags_reg;
`else
  assign hazard_eff = hazard;
  assign eval_flags = flags_reg;
`endif

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_cond
      assign pass_table[gi] = cond_pass(4'(gi), eval_flags);
    end
  endgenerate

  assign pass      = pass_table[bus.in_cond];
  assign undefined = (bus.in_cond == 4'hF);

  assign bus.in_ready = (!out_valid_reg || bus.out_ready) && !hazard_eff &&
                        (pend_count_reg != PEND_MAX);
  assign accept       = bus.in_valid && bus.in_ready;

  // Only instructions that actually execute will later write flags.
  assign pend_inc = accept && bus.in_sets_flags && pass && !undefined;
  assign pend_dec = flag_wr_valid && (pend_count_reg != '0);

  always_comb begin
    pend_count_next = pend_count_reg;
    if (pend_inc && !pend_dec)
      pend_count_next = pend_count_reg + PEND_ONE;
    else if (!pend_inc && pend_dec)
      pend_count_next = pend_count_reg - PEND_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg         <= '0;
      pend_count_reg    <= '0;
      err_underflow_reg <= 1'b0;
      out_valid_reg     <= 1'b0;
      out_execute_reg   <= 1'b0;
      out_undefined_reg <= 1'b0;
      out_tag_reg       <= '0;
    end else begin
      if (flag_wr_valid)
        flags_reg <= flag_wr_nzcv;
      if (flag_wr_valid && (pend_count_reg == '0))
        err_underflow_reg <= 1'b1;
      pend_count_reg <= pend_count_next;
      if (accept) begin
        out_valid_reg     <= 1'b1;
        out_execute_reg   <= pass;
        out_undefined_reg <= undefined;
        out_tag_reg       <= bus.in_tag;
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = out_valid_reg;
  assign bus.out_execute   = out_execute_reg;
  assign bus.out_undefined = out_undefined_reg;
  assign bus.out_tag       = out_tag_reg;
  assign flags_nzcv        = flags_reg;
  assign pend_count        = pend_count_reg;
  assign err_underflow     = err_underflow_reg;
endmodule

// File: doc/condition_checker.md
# condition_checker

Evaluation stage behind the condition decoder. Takes the decoded `Condition::Condition_Value` of each instruction together with a tag and tracks the architectural NZCV flags. Tells the execute stage whether the instruction runs, is squashed, or is undefined. Keeps a scoreboard of in-flight flag writes and stalls on the flag hazard, with optional same-cycle bypass of the write-back value.

## Interface
Parameters:
- `TAG_W`, 8, width of the opaque instruction tag passed through unchanged.
- `PEND_W`, 2, width of the pending-flag-write counter; maximum count is 2^PEND_W-1.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: an instruction is offered.
- `in_ready` out 1: the instruction is accepted on a cycle with `in_valid && in_ready`.
- `in_cond` in 4: `Condition_Value`; the numeric value equals the ARM cond field (Equal=0 … Always=0xE, Undefined=0xF).
- `in_sets_flags` in 1: the instruction writes NZCV in a later stage if it executes.
- `in_tag` in TAG_W: carried to `out_tag`.
- `flag_wr_valid` in 1: the write-back stage commits new flags this cycle.
- `flag_wr_nzcv` in 4: new flags, ordered {N,Z,C,V}.
- `out_valid` out 1: the result register holds an unconsumed result.
- `out_ready` in 1: the consumer accepts the result.
- `out_execute` out 1: the condition passed.
- `out_undefined` out 1: cond was 0xF.
- `out_tag` out TAG_W: tag of the result.
- `flags_nzcv` out 4: current registered flags.
- `pend_count` out PEND_W: number of flag writes in flight.
- `err_underflow` out 1: sticky flag; set when a flag write arrives with `pend_count==0`.

## Operation
Condition pass function, using flags F={N,Z,C,V}:
- 0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V.
- 8 C&!Z; 9 !C|Z; A N==V; B N!=V.
- C !Z&(N==V); D Z|(N!=V); E 1.
- F: pass=0 and `out_undefined`=1.

Flag hazard:
- `hazard = pend_count!=0 && in_cond not in {0xE,0xF}`.
- Conditions 0xE and 0xF never wait on flags.

Acceptance:
- `in_ready = (!out_valid || out_ready) && !hazard_eff && pend_count!=MAX`.
- `hazard_eff` is defined under Configuration.

Accepted instruction:
- Evaluates against the effective flags.
- Loads `out_execute`, `out_undefined` and `out_tag`; sets `out_valid`.
- If the register is not reloaded, `out_valid` clears on `out_valid && out_ready`.

Pending counter:
- +1 on an accept with `in_sets_flags && pass && !undefined`.
- A failed or undefined instruction never counts.
- −1 on `flag_wr_valid` when the count is >0.
- Increment and decrement in the same cycle leave the count unchanged.
- `flag_wr_valid` with count 0: flags still update, the count stays 0, `err_underflow` is set until reset.

Flags register:
- Loads `flag_wr_nzcv` on every `flag_wr_valid`.

Reset (asynchronous, any time):
- All state clears and any held result is dropped.
- Values: flags=0, `pend_count`=0, `out_valid`=0, `out_execute`=0, `out_undefined`=0, `out_tag`=0, `err_underflow`=0.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 per cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_valid`, `out_ready`, `pend_count`, `in_cond`, and (with bypass) `flag_wr_valid`.
- Outputs hold stable while `out_valid && !out_ready`.
- `flags_nzcv` and `pend_count` reflect a write one cycle after `flag_wr_valid`.
- Back-pressure: with `out_ready` low and `out_valid` high, `in_ready` is 0 and nothing is lost.

## Configuration
Macro `COND_FLAG_BYPASS_EN`:
- Defined:
  - `hazard_eff = hazard && !(flag_wr_valid && pend_count==1)`.
  - In that case evaluation uses `flag_wr_nzcv` instead of the registered flags. This removes the one-cycle bubble after the last outstanding write.
- Undefined:
  - `hazard_eff = hazard` and evaluation always uses the registered flags.
  - A dependent instruction is accepted at the earliest in the cycle after the write lands.

## Test plan
- Reset, then offer cond=0x0 with flags 0 and `out_ready`=1 -> one cycle later `out_valid`=1, `out_execute`=0. Then write NZCV=0100, offer 0x0 -> `out_execute`=1.
- Sweep all 16 conds against all 16 NZCV values -> `out_execute` matches the pass function; 0xF gives `out_undefined`=1 and `out_execute`=0.
- Accept 0xE with `in_sets_flags`=1, then offer 0x1:
  - `in_ready`=0 while `pend_count`=1.
  - `flag_wr_valid` with 0000 -> accepted the same cycle (bypass), or the next cycle (no bypass); `out_execute`=1.
- Offer 0x0 with `in_sets_flags`=1 and Z=0 -> squashed and `pend_count` stays 0. Issue 3 flag-setting 0xE -> `pend_count`=3 and `in_ready`=0 even for 0xE.
- Hold `out_ready`=0 for 5 cycles while `in_valid`=1 -> the output stays stable, then the next tag follows in order. `flag_wr_valid` at count 0 -> `err_underflow`=1.
- Assert `reset` mid-stream with `out_valid`=1 and `pend_count`=2 -> all outputs are 0 immediately.
